// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int index_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: synchronous write, combinational read;
// the parent registers the read word into its response.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W = index_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with WAIT_CYCLES wait states.
// Define DMEM_ALIGN_CHECK_EN to reject byte addresses that are not word aligned.
//
//   state | meaning
//   IDLE  | ready for a request, req_ready high
//   WAIT  | request latched, counting down wait states, access when count is 0
//   RESP  | response presented until rsp_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = index_width(DEPTH_WORDS);
    localparam int CNT_W = 4;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              lat_write;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic              accept;
    logic              access;
    logic              addr_err;
    logic              arr_we;
    logic [WORD_W-1:0] arr_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Anything above the word-index field addresses storage that does not exist.
`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_err = (|lat_addr[WORD_W-1:IDX_W+2]) | (|lat_addr[1:0]);
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^lat_addr[1:0];
    assign addr_err         = |lat_addr[WORD_W-1:IDX_W+2];
`endif

    assign arr_we = access & lat_write & ~addr_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                cnt       <= CNT_W'(WAIT_CYCLES);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (access) begin
                rsp_err   <= addr_err;
                rsp_rdata <= (!addr_err && !lat_write) ? arr_rdata : '0;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .wr_en (arr_we),
        .idx   (lat_addr[IDX_W+1:2]),
        .wdata (lat_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder; honours DMEM_ALIGN_CHECK_EN like the RTL.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int TB_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_write;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(TB_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [DEPTH];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int i);
        return (32'h0100_0193 * 32'(i + 1)) ^ 32'hA5A5_0000;
    endfunction

    // Memory seen as a plain array of words addressed by byte address / 4.
    function automatic void model_apply(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                        output logic [31:0] erd, output logic eer);
        eer = (a >= 32'(DEPTH * 4));
`ifdef DMEM_ALIGN_CHECK_EN
        if (a % 4 != 0) eer = 1'b1;
`endif
        erd = 32'h0;
        if (!eer) begin
            if (wr) mem_m[a / 4] = d;
            else    erd = mem_m[a / 4];
        end
    endfunction

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input int stall, output logic [31:0] rd, output logic er);
        int n;
        rsp_ready = (stall == 0);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("accept_timeout", 32'(n < 50), 32'd1);
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        check("latency", 32'(n), 32'(TB_WAIT + 1));
        rd = rsp_rdata;
        er = rsp_err;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, rd);
            check("stall_err", 32'(rsp_err), 32'(er));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_drop", 32'(rsp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    task automatic run_model(input logic wr, input logic [31:0] a, input logic [31:0] d, input int stall);
        logic [31:0] erd, rd;
        logic        eer, er;
        model_apply(wr, a, d, erd, eer);
        do_req(wr, a, d, stall, rd, er);
        check("model_rdata", rd, erd);
        check("model_err", 32'(er), 32'(eer));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, erd;
        logic        er, eer;
        int          n;

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;
        repeat (2) tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_z_req_ready", 32'(z_req_ready), 32'd1);
        reset = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) run_model(1'b1, 32'(i * 4), init_val(i), 0);

        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h0, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0400, 32'h0000_1234, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0, 32'hCAFE_F00D, 1'b0});
`ifdef DMEM_ALIGN_CHECK_EN
        vecs.push_back('{1'b1, 32'h0000_0012, 32'h1357_9BDF, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0401, 32'h0, 32'h0, 1'b1});
`else
        vecs.push_back('{1'b1, 32'h0000_0012, 32'h1357_9BDF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0, 32'h1357_9BDF, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0401, 32'h0, 32'h0, 1'b1});
`endif
        vecs.push_back('{1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0, init_val(255), 1'b0});
        vecs.push_back('{1'b1, 32'h0000_03FC, 32'h0BAD_CAFE, 32'h0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_03FC, 32'h0, 32'h0BAD_CAFE, 1'b0});

        foreach (vecs[k]) begin
            model_apply(vecs[k].wr, vecs[k].addr, vecs[k].wdata, erd, eer);
            do_req(vecs[k].wr, vecs[k].addr, vecs[k].wdata, 0, rd, er);
            check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
            check($sformatf("vec%0d_err", k), 32'(er), 32'(vecs[k].exp_err));
        end

        // Long response stall on a load.
        run_model(1'b0, 32'h0000_0010, 32'h0, 5);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = 32'($urandom_range(0, DEPTH * 4 - 1));
            run_model(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)));
        end

        // Reset one cycle after accepting a store: the store must be dropped.
        run_model(1'b0, 32'h0000_0004, 32'h0, 0);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA_5555;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        check("rstmid_accept_timeout", 32'(n < 50), 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        check("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid_rdata", rsp_rdata, 32'd0);
        check("rstmid_err", 32'(rsp_err), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        run_model(1'b0, 32'h0000_0020, 32'h0, 0);

        // Zero wait states, rsp_ready tied high, request held valid: store then streamed loads.
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h40; z_req_wdata = 32'h1111_2222;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (k == 0) begin
                z_req_write = 1'b0;
                z_req_wdata = $urandom;
            end
            check($sformatf("z%0d_rsp_valid", k), 32'(z_rsp_valid), 32'(k % 3 == 1));
            check($sformatf("z%0d_req_ready", k), 32'(z_req_ready), 32'(k % 3 == 2));
            if (k % 3 == 1) begin
                check($sformatf("z%0d_rdata", k), z_rsp_rdata, (k == 1) ? 32'h0 : 32'h1111_2222);
                check($sformatf("z%0d_err", k), 32'(z_rsp_err), 32'd0);
            end
        end
        z_req_valid = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
